// File: rtl/enc_secded_tx_if.sv
// Handshake bundle for the SEC-DED transmit encoder: data/injection request
// in, codeword out. The width derivation matches the one inside enc_secded_tx.
interface enc_secded_tx_if #(
  parameter int DATA_DEPTH = 8
);
  function automatic int chk_bits(input int d);
    int r;
    r = 1;
    while ((1 << r) < d + r + 1) r++;
    return r;
  endfunction

  localparam int CHK      = chk_bits(DATA_DEPTH);
  localparam int CW_WIDTH = DATA_DEPTH + CHK + 1;
  localparam int PW       = $clog2(CW_WIDTH);

  logic [DATA_DEPTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  inj_en;
  logic [PW-1:0]         inj_pos;
  logic [CW_WIDTH-1:0]   out_code;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in_data, in_valid, inj_en, inj_pos, out_ready,
    output in_ready, out_code, out_valid
  );

  modport master (
    output in_data, in_valid, inj_en, inj_pos, out_ready,
    input  in_ready, out_code, out_valid
  );
endinterface

// File: rtl/enc_secded_tx.sv
// SEC-DED Hamming encoder, 2-stage valid/ready pipeline with full backpressure,
// optional single-bit error injection and a wrapping delivered-word counter.
module enc_secded_tx #(
  parameter int DATA_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  enc_secded_tx_if.slave       bus,
  output logic [CNT_WIDTH-1:0] enc_count
);
  function automatic int chk_bits(input int d);
    int r;
    r = 1;
    while ((1 << r) < d + r + 1) r++;
    return r;
  endfunction

  localparam int CHK      = chk_bits(DATA_DEPTH);
  localparam int CW_WIDTH = DATA_DEPTH + CHK + 1;
  localparam int PW       = $clog2(CW_WIDTH);

  // Data fills the non-power-of-two positions; each check bit then covers the
  // positions whose index has its bit set, and bit 0 makes overall parity even.
  function automatic logic [CW_WIDTH-1:0] encode(input logic [DATA_DEPTH-1:0] d);
    logic [CW_WIDTH-1:0] c;
    logic                p;
    int                  di;
    c  = '0;
    di = 0;
    for (int j = 1; j < CW_WIDTH; j++) begin
      if ((j & (j - 1)) != 0) begin
        c[j] = d[di];
        di++;
      end
    end
    for (int k = 0; k < CHK; k++) begin
      p = 1'b0;
      for (int j = 1; j < CW_WIDTH; j++)
        if (((j >> k) & 1) == 1) p = p ^ c[j];
      c[1 << k] = p;
    end
    c[0] = ^c;
    return c;
  endfunction

  logic [DATA_DEPTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_inj_q, s1_inj_d;
  logic [PW-1:0]         s1_pos_q, s1_pos_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [CW_WIDTH-1:0]   out_code_q, out_code_d;
  logic                  out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  s2_load, in_ready, in_fire, out_fire, flip;
  logic [CW_WIDTH-1:0]   cw_clean, inj_mask;

  always_comb begin
    s2_load  = ~out_valid_q | bus.out_ready;
    in_ready = ~s1_valid_q | s2_load;
    in_fire  = bus.in_valid & in_ready;
    out_fire = out_valid_q & bus.out_ready;

    cw_clean = encode(s1_data_q);
    flip     = s1_inj_q && (int'(s1_pos_q) < CW_WIDTH);
    inj_mask = flip ? (CW_WIDTH'(1) << s1_pos_q) : '0;

    s1_data_d  = in_fire ? bus.in_data : s1_data_q;
    s1_inj_d   = in_fire ? bus.inj_en  : s1_inj_q;
    s1_pos_d   = in_fire ? bus.inj_pos : s1_pos_q;
    // Stage 1 drains into stage 2 and refills in the same cycle without a bubble.
    s1_valid_d = in_fire | (s1_valid_q & ~s2_load);

    out_valid_d = s2_load ? s1_valid_q : out_valid_q;
    out_code_d  = (s2_load & s1_valid_q) ? (cw_clean ^ inj_mask) : out_code_q;
    cnt_d       = cnt_q + CNT_WIDTH'(out_fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data_q   <= '0;
      s1_inj_q    <= 1'b0;
      s1_pos_q    <= '0;
      s1_valid_q  <= 1'b0;
      out_code_q  <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_data_q   <= s1_data_d;
      s1_inj_q    <= s1_inj_d;
      s1_pos_q    <= s1_pos_d;
      s1_valid_q  <= s1_valid_d;
      out_code_q  <= out_code_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_code  = out_code_q;
  assign bus.out_valid = out_valid_q;
  assign enc_count     = cnt_q;
endmodule

// File: tb/tb_enc_secded_tx.sv
// Scoreboard bench for enc_secded_tx: accepted words push a reference codeword,
// the output monitor pops and compares on every output handshake.
module tb_enc_secded_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  enc_secded_tx_if #(.DATA_DEPTH(8)) bus ();
  enc_secded_tx_if #(.DATA_DEPTH(8)) bus4 ();
  logic [15:0] enc_count;
  logic [3:0]  enc_count4;

  enc_secded_tx #(.DATA_DEPTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .enc_count(enc_count));
  enc_secded_tx #(.DATA_DEPTH(8), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .enc_count(enc_count4));

  typedef struct {
    logic [12:0] code;
    logic        clean;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_out  = 0;
  int   stalls = 0;

  // Reference: check bits come from the XOR of the indices of set data bits.
  function automatic logic [12:0] ref_enc(input logic [7:0] d, input logic inj,
                                          input logic [3:0] pos);
    logic [12:0] c;
    logic [3:0]  s;
    int          di;
    c = '0; s = '0; di = 0;
    for (int j = 1; j < 13; j++) begin
      if (j != 1 && j != 2 && j != 4 && j != 8) begin
        c[j] = d[di];
        if (d[di]) s = s ^ 4'(j);
        di++;
      end
    end
    c[1] = s[0]; c[2] = s[1]; c[4] = s[2]; c[8] = s[3];
    c[0] = ^c[12:1];
    if (inj && pos < 4'd13) c[pos] = ~c[pos];
    return c;
  endfunction

  task automatic monitor();
    exp_t e;
    int   s;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        n_out++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected: got code %h, expected no output", bus.out_code);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_code !== e.code) begin
            n_bad++;
            $display("FAIL sb_code: got %h, expected %h", bus.out_code, e.code);
          end
          if (e.clean) begin
            s = 0;
            for (int j = 1; j < 13; j++) if (bus.out_code[j]) s = s ^ j;
            n_cmp++;
            if (s != 0 || (^bus.out_code) !== 1'b0) begin
              n_bad++;
              $display("FAIL sb_parity: code %h syndrome %0d parity %b, expected 0/0",
                       bus.out_code, s, ^bus.out_code);
            end
          end
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic inj, input logic [3:0] pos);
    bit   acc;
    int   tries;
    exp_t e;
    acc = 0; tries = 0;
    bus.in_data = d; bus.inj_en = inj; bus.inj_pos = pos; bus.in_valid = 1'b1;
    while (!acc && tries < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) begin
        e.code  = ref_enc(d, inj, pos);
        e.clean = !(inj && pos < 4'd13);
        exp_q.push_back(e);
      end else stalls++;
      @(posedge clk); #1;
      tries++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: word %h not accepted, expected in_ready", d);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.out_ready = 0; bus.in_data = '0; bus.inj_en = 0; bus.inj_pos = '0;
    bus4.in_valid = 0; bus4.out_ready = 0; bus4.in_data = '0; bus4.inj_en = 0; bus4.inj_pos = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b, expected 0", bus.out_valid); end
    n_cmp++; if (bus.out_code !== 13'h0) begin n_bad++; $display("FAIL rst_code: got %h, expected 0", bus.out_code); end
    n_cmp++; if (enc_count !== 16'h0) begin n_bad++; $display("FAIL rst_count: got %0d, expected 0", enc_count); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b, expected 1", bus.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0]  din [3];
    logic [12:0] cw  [3];
    din = '{8'h00, 8'hFF, 8'h01};
    cw  = '{13'h0000, 13'h1EEE, 13'h000F};
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(din[i], 1'b0, 4'd0);
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_lat1: word %0d valid %b, expected 0", i, bus.out_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_code !== cw[i]) begin
        n_bad++;
        $display("FAIL basic_code: word %0d valid %b code %h, expected 1 %h", i, bus.out_valid, bus.out_code, cw[i]);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++; if (enc_count !== 16'd3) begin n_bad++; $display("FAIL basic_count: got %0d, expected 3", enc_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int s0, mx, run;
    do_reset();
    bus.out_ready = 1'b1;
    s0 = stalls; mx = 0; run = 0;
    fork
      for (int i = 0; i < 10; i++) send(8'(i), 1'b0, 4'd0);
      repeat (16) begin
        @(negedge clk);
        if (bus.out_valid) begin run++; if (run > mx) mx = run; end
        else run = 0;
      end
    join
    @(negedge clk);
    n_cmp++; if (stalls != s0) begin n_bad++; $display("FAIL b2b_stall: got %0d stalls, expected 0", stalls - s0); end
    n_cmp++; if (mx != 10) begin n_bad++; $display("FAIL b2b_run: got %0d consecutive valid, expected 10", mx); end
    n_cmp++; if (enc_count !== 16'd10) begin n_bad++; $display("FAIL b2b_count: got %0d, expected 10", enc_count); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_drain: %0d left, expected 0", exp_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int          s0, n0;
    logic [12:0] first;
    do_reset();
    bus.out_ready = 1'b0;
    n0 = n_out;
    first = ref_enc(8'hA0, 1'b0, 4'd0);
    send(8'hA0, 1'b0, 4'd0);
    send(8'hA1, 1'b0, 4'd0);
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready: got %b, expected 0", bus.in_ready); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_code !== first) begin
      n_bad++; $display("FAIL bp_hold: valid %b code %h, expected 1 %h", bus.out_valid, bus.out_code, first);
    end
    @(posedge clk); #1;
    s0 = stalls;
    fork
      for (int i = 2; i < 5; i++) send(8'hA0 + 8'(i), 1'b0, 4'd0);
      begin repeat (3) @(posedge clk); #1; bus.out_ready = 1'b1; end
    join
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (stalls <= s0) begin n_bad++; $display("FAIL bp_stall: got %0d stalls, expected >0", stalls - s0); end
    n_cmp++; if (enc_count !== 16'd5) begin n_bad++; $display("FAIL bp_count: got %0d, expected 5", enc_count); end
    n_cmp++; if (n_out - n0 != 5) begin n_bad++; $display("FAIL bp_outs: got %0d outputs, expected 5", n_out - n0); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL bp_drain: %0d left, expected 0", exp_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_injection();
    logic        inj [4];
    logic [3:0]  pos [4];
    logic [12:0] cw  [4];
    inj = '{1'b1, 1'b1, 1'b1, 1'b0};
    pos = '{4'd3, 4'd0, 4'd13, 4'd3};
    cw  = '{13'h1EE6, 13'h1EEF, 13'h1EEE, 13'h1EEE};
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(8'hFF, inj[i], pos[i]);
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_code !== cw[i]) begin
        n_bad++;
        $display("FAIL inj_code: case %0d valid %b code %h, expected 1 %h", i, bus.out_valid, bus.out_code, cw[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    bus.out_ready = 1'b0;
    send(8'h11, 1'b0, 4'd0);
    send(8'h22, 1'b0, 4'd0);
    do_reset();
    n0 = n_out;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b, expected 0", bus.out_valid); end
    n_cmp++; if (enc_count !== 16'd0) begin n_bad++; $display("FAIL mid_count: got %0d, expected 0", enc_count); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b, expected 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (n_out != n0) begin n_bad++; $display("FAIL mid_stale: got %0d outputs, expected 0", n_out - n0); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int acc, t;
    do_reset();
    bus4.out_ready = 1'b1;
    bus4.in_valid  = 1'b1;
    acc = 0; t = 0;
    while (acc < 17 && t < 100) begin
      @(negedge clk);
      if (bus4.in_ready) acc++;
      @(posedge clk); #1;
      bus4.in_data = bus4.in_data + 8'd1;
      t++;
    end
    bus4.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (acc != 17) begin n_bad++; $display("FAIL wrap_accept: got %0d, expected 17", acc); end
    n_cmp++; if (enc_count4 !== 4'd1) begin n_bad++; $display("FAIL wrap_count: got %0d, expected 1", enc_count4); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int n0;
    bit done;
    do_reset();
    n0 = n_out; done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(8'($urandom), $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));
        done = 1;
      end
      while (!done) begin
        @(posedge clk); #1;
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
    join
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (n_out - n0 != 40) begin n_bad++; $display("FAIL rnd_outs: got %0d outputs, expected 40", n_out - n0); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rnd_drain: %0d left, expected 0", exp_q.size()); end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    fork monitor(); join_none
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_injection();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
